// File: rtl/button_conditioner.sv
// Push-button front end: per channel a 2-flop synchronizer, a debounce/auto-repeat FSM and registered DPB/SCEN/MCEN.
// Optional macro BTN_LOCKOUT_EN: the channel that owns a press suppresses SCEN/MCEN from every other channel.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] BtnIn,
    output logic [N_BTN-1:0] DPB,
    output logic [N_BTN-1:0] SCEN,
    output logic [N_BTN-1:0] MCEN,
    output logic             AnyPressed
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        ARM    = 5'b00010,
        PRESS  = 5'b00100,
        REPEAT = 5'b01000,
        DISARM = 5'b10000
    } state_e;

    logic [N_BTN-1:0] dpb_d_w;
    logic             any_q;

`ifdef BTN_LOCKOUT_EN
    logic [N_BTN-1:0] owner_w;
    logic [N_BTN-1:0] enter_w;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            logic             sync1_q;
            logic             s_in_q;
            state_e           state_q;
            state_e           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             dpb_q;
            logic             dpb_d;
            logic             scen_q;
            logic             scen_d;
            logic             mcen_q;
            logic             mcen_d;
            logic             enter;
            logic             rpt;
            logic             suppress;

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    sync1_q <= 1'b0;
                    s_in_q  <= 1'b0;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    dpb_q   <= 1'b0;
                    scen_q  <= 1'b0;
                    mcen_q  <= 1'b0;
                end else begin
                    sync1_q <= BtnIn[gi];
                    s_in_q  <= sync1_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    dpb_q   <= dpb_d;
                    scen_q  <= scen_d;
                    mcen_q  <= mcen_d;
                end
            end

            // A low sample always wins over a terminal count, so a release never emits a final repeat.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q + 1'b1;
                enter   = 1'b0;
                rpt     = 1'b0;
                case (state_q)
                    IDLE: begin
                        cnt_d = '0;
                        if (s_in_q) state_d = ARM;
                    end
                    ARM: begin
                        if (!s_in_q) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = PRESS;
                            cnt_d   = '0;
                            enter   = 1'b1;
                        end
                    end
                    PRESS: begin
                        if (!s_in_q) begin
                            state_d = DISARM;
                            cnt_d   = '0;
                        end else if (cnt_q == DLY_LAST) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                            rpt     = 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!s_in_q) begin
                            state_d = DISARM;
                            cnt_d   = '0;
                        end else if (cnt_q == PER_LAST) begin
                            cnt_d = '0;
                            rpt   = 1'b1;
                        end
                    end
                    DISARM: begin
                        if (s_in_q) begin
                            state_d = PRESS;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign dpb_d  = (state_d == PRESS) || (state_d == REPEAT) || (state_d == DISARM);
            assign scen_d = enter & ~suppress;
            assign mcen_d = (enter | rpt) & ~suppress;

`ifdef BTN_LOCKOUT_EN
            logic lock_q;
            logic lock_d;
            logic blocked;

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    lock_q <= 1'b0;
                end else begin
                    lock_q <= lock_d;
                end
            end

            assign enter_w[gi] = enter;
            assign owner_w[gi] = ((state_q == PRESS) || (state_q == REPEAT) || (state_q == DISARM)) & ~lock_q;

            // The lock verdict is taken once, on the accepted press, and held until the channel is idle again.
            always_comb begin
                blocked = 1'b0;
                for (int j = 0; j < N_BTN; j++) begin
                    if ((j != gi) && owner_w[j]) blocked = 1'b1;
                    if ((j < gi) && enter_w[j]) blocked = 1'b1;
                end
                lock_d = lock_q;
                if (enter) begin
                    lock_d = blocked;
                end else if (state_d == IDLE) begin
                    lock_d = 1'b0;
                end
            end

            assign suppress = lock_d;
`else
            assign suppress = 1'b0;
`endif

            assign dpb_d_w[gi] = dpb_d;
            assign DPB[gi]     = dpb_q;
            assign SCEN[gi]    = scen_q;
            assign MCEN[gi]    = mcen_q;
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |dpb_d_w;
        end
    end

    assign AnyPressed = any_q;

endmodule
